is_div_3_seq: RTL
=================

// Module: is_div_3_seq
// PURPOSE
// Sequential, handshaked divisibility-by-3 engine. It accepts a SIZE-bit digit from an upstream producer and
// folds it MSB-first, BITS_PER_CYCLE bits per clock, through a mod-3 remainder register. It then presents
// the verdict (out) and remainder (rem) to a downstream consumer. It is the multi-cycle, area-lean stage
// paired with the combinational is_div_3_top, with identical results: out == !(digit % 3).
// PARAMETERS
// SIZE            64  width of digit; must be a multiple of BITS_PER_CYCLE
// BITS_PER_CYCLE  2   digit bits folded per clock (1..SIZE)
// PORTS
// clk        in   1        clock; all state updates on rising edge
// rst        in   1        synchronous reset, active-high
// in_valid   in   1        upstream has a digit on `digit`
// in_ready   out  1        engine can accept a digit (IDLE only)
// digit      in   SIZE     operand; sampled only on in_valid && in_ready
// out_valid  out  1        out/rem hold a result
// out_ready  in   1        downstream accepts result
// out        out  1        1 when the accepted digit is divisible by 3
// rem        out  2        digit % 3; values 0..2, 3 never produced
// BEHAVIOUR
// - One clock (clk). rst is synchronous and active-high.
// - Reset values: state = IDLE, in_ready = 1, out_valid = 0, out = 0, rem = 0, step counter = 0.
// - FSM states: IDLE, RUN, DONE (encoding in package).
//   IDLE: in_ready = 1. On in_valid: load shift register with digit, clear remainder, clear counter, go to RUN.
//   RUN: in_ready = 0, out_valid = 0. Each cycle, take the top BITS_PER_CYCLE bits of the shift register,
//     MSB first. Update r <= (r*2^BITS_PER_CYCLE + chunk) mod 3. Shift left by BITS_PER_CYCLE and increment
//     the counter. After STEPS = SIZE/BITS_PER_CYCLE updates, go to DONE.
//   DONE: out_valid = 1, rem = r, out = (r == 0). All three stay stable until out_ready is sampled high.
//     On out_ready, go to IDLE.
// - Latency: out_valid rises exactly STEPS clocks after the accepting edge (SIZE=64, BPC=2 -> 32 clocks).
// - Throughput: one digit per STEPS+2 clocks.
//   - No overlap: in_ready = 0 in RUN and DONE.
//   - There is no same-cycle DONE->accept path; in_ready is asserted the cycle after the result is consumed.
// - Remainder arithmetic is 2-bit; every intermediate is reduced mod 3 each step. No SIZE-wide divider.
// - digit changes outside the accepting edge have no effect. in_valid held across RUN is ignored until IDLE.
// - out_ready while not in DONE is ignored.
// - rst in any state (including mid-RUN or DONE with a pending result) aborts the operation:
//   - The next cycle shows the reset values.
//   - The pending result is discarded, not delivered.
// - out/rem are registered. Outside DONE they hold their reset/last-cleared value of 0 and are only meaningful
//   while out_valid = 1.
// STRUCTURE
// - Package is_div_3_pkg: state enum/localparams (IDLE/RUN/DONE), STEPS = SIZE/BITS_PER_CYCLE,
//   counter width = $clog2(STEPS)+1, and the mod-3 single-bit transition table: r' = (2r + b) mod 3.
// - Sub-module mod3_fold: purely combinational. It takes r_in[1:0] and chunk[BITS_PER_CYCLE-1:0] and
//   returns r_out[1:0] by applying the bit transition BITS_PER_CYCLE times, MSB first.
// - Top: FSM, shift register, counter, and the output register.
// TESTING
// - Reset: hold rst 3 clocks -> in_ready=1, out_valid=0, out=0, rem=0.
// - digit=0 -> out_valid after 32 clocks, out=1, rem=0.
// - digit=7 -> out=0, rem=1.
// - digit=64'hFFFF_FFFF_FFFF_FFFF -> out=1, rem=0.
// - Backpressure: digit=5, out_ready low 5 clocks in DONE -> out_valid, out=0, rem=2 held stable.
//   - in_ready stays 0 throughout.
//   - Result consumed on the first out_ready=1.
// - Reset mid-RUN: accept digit=3, assert rst at clock 10 -> the next cycle shows IDLE reset values and no
//   out_valid ever appears.
//   - Then accept digit=4 -> rem=1.
// - Sweep digit 1..128 back-to-back with out_ready=1 -> every result equals !(digit%3) and digit%3.
//   - Also rerun the sweep with BITS_PER_CYCLE=1 (64-clock latency) and =8 (8-clock latency).

Source files
------------

// File: rtl/is_div_3_pkg.sv
// Shared types and helpers for the sequential divisibility-by-3 engine.
// Holds the FSM encoding, step/counter sizing and the single-bit mod-3 transition.
package is_div_3_pkg;

    localparam int unsigned SIZE_DEF = 64;
    localparam int unsigned BPC_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned steps(input int unsigned size, input int unsigned bpc);
        return size / bpc;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned size, input int unsigned bpc);
        return $clog2(size / bpc) + 1;
    endfunction

    // r' = (2r + b) mod 3; r == 3 cannot occur
    function automatic logic [1:0] mod3_bit(input logic [1:0] r, input logic b);
        logic [1:0] r_next;
        case (r)
            2'd0:    r_next = b ? 2'd1 : 2'd0;
            2'd1:    r_next = b ? 2'd0 : 2'd2;
            2'd2:    r_next = b ? 2'd2 : 2'd1;
            default: r_next = 2'd0;
        endcase
        return r_next;
    endfunction

endpackage

// File: rtl/is_div_3_seq_if.sv
// Handshake bundle for is_div_3_seq: operand in, verdict and remainder out.
// The master drives digits and consumes results; the slave is the engine.
interface is_div_3_seq_if #(
    parameter int unsigned SIZE = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] digit;
    logic            out_valid;
    logic            out_ready;
    logic            out;
    logic [1:0]      rem;

    modport master (
        output in_valid, digit, out_ready,
        input  in_ready, out_valid, out, rem
    );

    modport slave (
        input  in_valid, digit, out_ready,
        output in_ready, out_valid, out, rem
    );
endinterface

// File: rtl/is_div_3_seq_mod3_fold.sv
// Combinational mod-3 fold of one chunk into a running remainder, MSB first.
// Each chunk bit applies r' = (2r + b) mod 3 so the remainder never exceeds 2 bits.
module mod3_fold
    import is_div_3_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic [1:0]                i_r,
    input  logic [BITS_PER_CYCLE-1:0] i_chunk,
    output logic [1:0]                o_r
);

    logic [1:0] w_acc;

    always_comb begin
        w_acc = i_r;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            w_acc = mod3_bit(w_acc, i_chunk[i]);
        end
        o_r = w_acc;
    end

endmodule

// File: rtl/is_div_3_seq.sv
// Multi-cycle divisibility-by-3 engine: accepts a digit, folds BITS_PER_CYCLE bits per clock
// through a 2-bit remainder, then holds out/rem until the consumer takes them.
module is_div_3_seq
    import is_div_3_pkg::*;
#(
    parameter int unsigned SIZE           = SIZE_DEF,
    parameter int unsigned BITS_PER_CYCLE = BPC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    is_div_3_seq_if.slave bus
);

    localparam int unsigned STEPS = steps(SIZE, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = cnt_width(SIZE, BITS_PER_CYCLE);

    state_e          r_state;
    state_e          w_state_next;
    logic [SIZE-1:0] r_shift;
    logic [1:0]      r_acc;
    logic [1:0]      w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic            r_out;
    logic [1:0]      r_rem;
    logic            w_last;

    mod3_fold #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_fold (
        .i_r    (r_acc),
        .i_chunk(r_shift[SIZE-1 -: BITS_PER_CYCLE]),
        .o_r    (w_acc_next)
    );

    assign w_last = (r_cnt == CNT_W'(STEPS - 1));

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.out = r_out;
    assign bus.rem = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_acc   <= 2'd0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= bus.digit;
                        r_acc   <= 2'd0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_shift <= r_shift << BITS_PER_CYCLE;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Result registers load on the final fold so they are valid on entering DONE
                    if (w_last) begin
                        r_rem <= w_acc_next;
                        r_out <= (w_acc_next == 2'd0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out <= 1'b0;
                        r_rem <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
